// File: rtl/rr_reg_mux_pkg.sv
// rr_reg_mux_pkg: shared mode encodings and select-width derivation
package rr_reg_mux_pkg;
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR = 1'b1;
  function automatic int sel_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_reg_mux_if.sv
// rr_reg_mux_if: producer/consumer handshake bundle for rr_reg_mux
interface rr_reg_mux_if #(parameter int WIDTH = 16, parameter int NUM_IN = 4);
  import rr_reg_mux_pkg::*;
  localparam int SEL_W = sel_w(NUM_IN);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0] in_valid;
  logic [NUM_IN-1:0] in_ready;
  logic mode;
  logic [SEL_W-1:0] control;
  logic [WIDTH-1:0] out;
  logic out_valid;
  logic [SEL_W-1:0] out_chan;
  logic out_ready;
  modport master (output in_data, in_valid, mode, control, out_ready,
                  input in_ready, out, out_valid, out_chan);
  modport slave (input in_data, in_valid, mode, control, out_ready,
                 output in_ready, out, out_valid, out_chan);
endinterface

// File: rtl/rr_reg_mux_arbiter.sv
// rr_reg_mux_arbiter: combinational round-robin pick starting at ptr
module rr_reg_mux_arbiter
  import rr_reg_mux_pkg::*;
#(
  parameter int NUM_IN = 4,
  localparam int SEL_W = sel_w(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_IN-1:0] gnt,
  output logic [SEL_W-1:0]  idx
);
  function automatic logic [SEL_W-1:0] wrap(input logic [SEL_W-1:0] p, input int i);
    int c = int'(p) + i;
    return SEL_W'(c >= NUM_IN ? c - NUM_IN : c);
  endfunction
  // scan from the far end so the channel nearest ptr is written last and wins
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = NUM_IN - 1; i >= 0; i--)
      if (req[wrap(ptr, i)]) begin
        gnt = NUM_IN'(1) << wrap(ptr, i);
        idx = wrap(ptr, i);
      end
  end
endmodule

// File: rtl/rr_reg_mux.sv
// rr_reg_mux: registered N:1 mux with valid/ready, backpressure and round-robin mode
module rr_reg_mux
  import rr_reg_mux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NUM_IN = 4,
  localparam int SEL_W = sel_w(NUM_IN)
) (
  input logic clock,
  input logic reset,
  rr_reg_mux_if.slave bus
);
  logic [SEL_W-1:0] ptr, rr_idx, gidx;
  logic [NUM_IN-1:0] rr_gnt, d_gnt, gnt;
  logic load, gnt_ok;
  rr_reg_mux_arbiter #(.NUM_IN(NUM_IN)) u_arb (
    .req(bus.in_valid), .ptr(ptr), .gnt(rr_gnt), .idx(rr_idx)
  );
  // out-of-range control shifts the bit away, so it can never grant
  assign d_gnt = bus.in_valid & (NUM_IN'(1) << bus.control);
  assign gnt = bus.mode == MODE_RR ? rr_gnt : d_gnt;
  assign gidx = bus.mode == MODE_RR ? rr_idx : bus.control;
  assign gnt_ok = |gnt;
  assign load = !bus.out_valid | bus.out_ready;
  assign bus.in_ready = (load & !reset) ? gnt : '0;
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.out <= '0;
      bus.out_valid <= 1'b0;
      bus.out_chan <= '0;
      ptr <= '0;
    end else if (load) begin
      bus.out_valid <= gnt_ok;
      if (gnt_ok) begin
        bus.out <= bus.in_data[int'(gidx)*WIDTH +: WIDTH];
        bus.out_chan <= gidx;
        if (bus.mode == MODE_RR) ptr <= rr_idx == SEL_W'(NUM_IN - 1) ? '0 : rr_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rr_reg_mux.sv
// tb_rr_reg_mux: directed checks of rr_reg_mux (4-input and 3-input builds)
module tb_rr_reg_mux;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  rr_reg_mux_if #(.WIDTH(16), .NUM_IN(4)) b ();
  rr_reg_mux_if #(.WIDTH(16), .NUM_IN(3)) b3 ();
  rr_reg_mux #(.WIDTH(16), .NUM_IN(4)) dut (.clock(clock), .reset(reset), .bus(b));
  rr_reg_mux #(.WIDTH(16), .NUM_IN(3)) dut3 (.clock(clock), .reset(reset), .bus(b3));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic out_is(input string tag, input logic [15:0] d, input logic [1:0] c, input logic v);
    chk({tag, ".out"}, 32'(b.out), 32'(d));
    chk({tag, ".chan"}, 32'(b.out_chan), 32'(c));
    chk({tag, ".valid"}, 32'(b.out_valid), 32'(v));
  endtask
  initial begin
    logic [1:0] rr_seq [6] = '{0, 1, 2, 3, 0, 1};
    b.in_data = '0; b.in_valid = '0; b.mode = 1'b0; b.control = '0; b.out_ready = 1'b0;
    b3.in_data = {16'h000C, 16'h000B, 16'h000A}; b3.in_valid = '0; b3.mode = 1'b0;
    b3.control = '0; b3.out_ready = 1'b0;
    tick();
    b.control = 2; b.in_valid = 4'b0100; b.in_data[2*16 +: 16] = 16'hBEEF; b.out_ready = 1'b1;
    #1 chk("rst_in_ready", 32'(b.in_ready), 0);
    tick();
    out_is("reset", 16'h0, 0, 0);
    reset = 1'b0;
    #1 chk("direct_in_ready", 32'(b.in_ready), 32'b0100);
    tick();
    out_is("direct", 16'hBEEF, 2, 1);
    b.out_ready = 1'b0; b.control = 1; b.in_valid = 4'b0010; b.in_data[1*16 +: 16] = 16'h1111;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_in_ready", 32'(b.in_ready), 0);
      tick();
      out_is("stall", 16'hBEEF, 2, 1);
    end
    b.out_ready = 1'b1;
    #1 chk("unstall_in_ready", 32'(b.in_ready), 32'b0010);
    tick();
    out_is("unstall", 16'h1111, 1, 1);
    b.mode = 1'b1; b.in_valid = 4'b1111;
    b.in_data = {16'h0030, 16'h0020, 16'h0010, 16'h0000};
    for (int i = 0; i < 6; i++) begin
      #1 chk("rr_in_ready", 32'(b.in_ready), 32'(4'b0001 << rr_seq[i]));
      tick();
      out_is("rr_fair", 16'(rr_seq[i]) << 4, rr_seq[i], 1);
    end
    b.in_valid = 4'b0100;
    tick();
    out_is("rr_to3", 16'h0020, 2, 1);
    b.in_valid = 4'b0011;
    #1 chk("wrap_in_ready", 32'(b.in_ready), 32'b0001);
    tick();
    out_is("wrap0", 16'h0000, 0, 1);
    tick();
    out_is("wrap1", 16'h0010, 1, 1);
    b.in_valid = 4'b1111;
    #1 chk("ptr_after_wrap", 32'(b.in_ready), 32'b0100);
    b.in_valid = 4'b0000;
    tick();
    out_is("idle", 16'h0010, 1, 0);
    b.in_valid = 4'b1111;
    #1 chk("ptr_after_idle", 32'(b.in_ready), 32'b0100);
    b.mode = 1'b0; b.control = 0; b.in_valid = 4'b0001;
    tick();
    out_is("direct0", 16'h0000, 0, 1);
    b.mode = 1'b1; b.in_valid = 4'b1111;
    #1 chk("ptr_after_direct", 32'(b.in_ready), 32'b0100);
    b3.control = 3; b3.in_valid = 3'b111; b3.out_ready = 1'b1;
    #1 chk("n3_ctrl3_ready", 32'(b3.in_ready), 0);
    tick();
    chk("n3_ctrl3_valid", 32'(b3.out_valid), 0);
    out_is("rr_load2", 16'h0020, 2, 1);
    b.out_ready = 1'b0;
    b3.control = 2;
    #1 chk("n3_ctrl2_ready", 32'(b3.in_ready), 32'b100);
    tick();
    chk("n3_ctrl2_out", 32'(b3.out), 32'h000C);
    chk("n3_ctrl2_chan", 32'(b3.out_chan), 2);
    out_is("stall2", 16'h0020, 2, 1);
    b3.mode = 1'b1; b3.in_valid = 3'b100;
    tick();
    chk("n3_rr_chan", 32'(b3.out_chan), 2);
    b3.in_valid = 3'b111;
    #1 chk("n3_rr_wrap", 32'(b3.in_ready), 32'b001);
    b.out_ready = 1'b1; b.in_valid = 4'b1111;
    #1 chk("pre_reset_ready", 32'(b.in_ready), 32'b1000);
    b.out_ready = 1'b0;
    reset = 1'b1;
    b.out_ready = 1'b1;
    #1 chk("in_reset_ready", 32'(b.in_ready), 0);
    out_is("reset_between_edges", 16'h0020, 2, 1);
    tick();
    out_is("mid_reset", 16'h0, 0, 0);
    reset = 1'b0;
    #1 chk("ptr_after_reset", 32'(b.in_ready), 32'b0001);
    tick();
    out_is("post_reset", 16'h0000, 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
